// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_param core: parity encodings, the TX and RX
// FSM state enums, the receiver oversample factor and the parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Receiver oversample factor (ticks per bit period).
   localparam int OS = 16;

   // Parity mode encodings, matching the PARITY parameter of uart_param.
   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   // Parity bit for a payload. Narrower payloads are zero-extended, which
   // does not change the count of ones.
   function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
      logic ones_odd;
      ones_odd = ^data;
      case (mode)
         PAR_ODD:  calc_parity = ~ones_odd;
         PAR_EVEN: calc_parity = ones_odd;
         default:  calc_parity = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Divide-by-DIV tick generator for the receiver oversample clock enable.
// A synchronous restart re-aligns the tick phase so that the first tick after
// restart arrives DIV cycles later.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   restart in  synchronous phase restart
//   tick    out one-cycle pulse every DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          tick_r;

   // Next divider count: restart wins, otherwise wrap at LAST.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (restart) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (cnt_r == LAST) begin
         cnt_nxt_s = {CW{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Divider register; the tick is registered from the next count so it
   // lines up with the cycle in which the count sits at LAST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= {CW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == LAST);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_param.sv
// -----------------------------------------------------------------------------
// uart_param
// Parametrised full-duplex UART: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, STOP_BITS stop bits. The receiver oversamples 16x
// and flags parity and framing errors per frame.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   tx_start        send request, sampled only while tx_busy = 0
//   tx_data         payload, captured on acceptance
//   tx_busy         high while a frame is on the line
//   tx_done         one-cycle pulse in the last cycle of the frame
//   txd             serial output, idles high
//   rxd             serial input, asynchronous to clk
//   rx_data         last received payload
//   rx_valid        one-cycle pulse per received frame
//   rx_parity_err   parity mismatch for the frame flagged by rx_valid
//   rx_frame_err    first stop bit sampled low for that frame
// -----------------------------------------------------------------------------
module uart_param
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 2,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 txd,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err
);

   localparam int BIT_CLKS   = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int OS_DIV_RAW = (CLK_HZ + (OS * BAUD) / 2) / (OS * BAUD);
   localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
   localparam int STOP_CLKS  = STOP_BITS * BIT_CLKS;
   localparam int CNT_W      = $clog2(STOP_CLKS + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [1:0]       PAR_MODE  = 2'(PARITY);
   localparam logic             HAS_PAR   = (PARITY != 0);
   localparam logic [3:0]       OS_MID    = 4'(OS / 2 - 1);
   localparam logic [3:0]       OS_LAST   = 4'(OS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
      $error("uart_param: DATA_BITS, PARITY or STOP_BITS out of range");
   end

   // ------------------------------------------------------------------ TX
   tx_state_e            tx_state_r, tx_state_n;
   logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_n;
   logic [2:0]           tx_idx_r, tx_idx_n;
   logic [DATA_BITS-1:0] tx_data_r, tx_data_n;
   logic                 tx_line_n;
   logic                 tx_done_n;
   logic                 txd_r, tx_busy_r, tx_done_r;

   // TX next-state: each state is held for its bit time, counter reloads on change.
   always_comb begin
      tx_state_n = tx_state_r;
      tx_cnt_n   = tx_cnt_r;
      tx_idx_n   = tx_idx_r;
      tx_data_n  = tx_data_r;
      case (tx_state_r)
         TX_IDLE: begin
            if (tx_start) begin
               tx_state_n = TX_START;
               tx_cnt_n   = {CNT_W{1'b0}};
               tx_idx_n   = 3'd0;
               tx_data_n  = tx_data;
            end else begin
               tx_state_n = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_state_n = TX_DATA;
               tx_cnt_n   = {CNT_W{1'b0}};
            end else begin
               tx_cnt_n = tx_cnt_r + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_cnt_n = {CNT_W{1'b0}};
               if (tx_idx_r == DATA_LAST) begin
                  tx_idx_n   = 3'd0;
                  tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
               end else begin
                  tx_idx_n = tx_idx_r + 3'd1;
               end
            end else begin
               tx_cnt_n = tx_cnt_r + CNT_W'(1);
            end
         end
         TX_PARITY: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_state_n = TX_STOP;
               tx_cnt_n   = {CNT_W{1'b0}};
            end else begin
               tx_cnt_n = tx_cnt_r + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt_r == STOP_LAST) begin
               tx_state_n = TX_IDLE;
               tx_cnt_n   = {CNT_W{1'b0}};
            end else begin
               tx_cnt_n = tx_cnt_r + CNT_W'(1);
            end
         end
         default: begin
            tx_state_n = TX_IDLE;
            tx_cnt_n   = {CNT_W{1'b0}};
            tx_idx_n   = 3'd0;
         end
      endcase
   end

   // TX line level and done flag for the next cycle, so the outputs can be registered.
   always_comb begin
      tx_line_n = 1'b1;
      case (tx_state_n)
         TX_START:  tx_line_n = 1'b0;
         TX_DATA:   tx_line_n = tx_data_n[tx_idx_n];
         TX_PARITY: tx_line_n = calc_parity(8'(tx_data_n), PAR_MODE);
         TX_STOP:   tx_line_n = 1'b1;
         default:   tx_line_n = 1'b1;
      endcase
      tx_done_n = (tx_state_n == TX_STOP) && (tx_cnt_n == STOP_LAST);
   end

   // TX state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= {CNT_W{1'b0}};
         tx_idx_r   <= 3'd0;
         tx_data_r  <= {DATA_BITS{1'b0}};
         txd_r      <= 1'b1;
         tx_busy_r  <= 1'b0;
         tx_done_r  <= 1'b0;
      end else begin
         tx_state_r <= tx_state_n;
         tx_cnt_r   <= tx_cnt_n;
         tx_idx_r   <= tx_idx_n;
         tx_data_r  <= tx_data_n;
         txd_r      <= tx_line_n;
         tx_busy_r  <= (tx_state_n != TX_IDLE);
         tx_done_r  <= tx_done_n;
      end
   end

   assign txd     = txd_r;
   assign tx_busy = tx_busy_r;
   assign tx_done = tx_done_r;

   // ------------------------------------------------------------------ RX
   logic                 rxd_meta_r, rxd_sync_r, rxd_prev_r;
   logic                 fall_s;
   logic                 os_tick_s;
   logic                 restart_s;
   logic                 deliver_s;
   rx_state_e            rx_state_r, rx_state_n;
   logic [3:0]           rx_tick_r, rx_tick_n;
   logic [2:0]           rx_idx_r, rx_idx_n;
   logic [DATA_BITS-1:0] rx_shift_r, rx_shift_n;
   logic                 rx_perr_r, rx_perr_n;
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_valid_r, rx_parity_err_r, rx_frame_err_r;

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_r <= 1'b1;
         rxd_sync_r <= 1'b1;
         rxd_prev_r <= 1'b1;
      end else begin
         rxd_meta_r <= rxd;
         rxd_sync_r <= rxd_meta_r;
         rxd_prev_r <= rxd_sync_r;
      end
   end

   assign fall_s = rxd_prev_r & ~rxd_sync_r;

   uart_baud_gen #(
      .DIV(OS_DIV)
   ) u_baud_gen (
      .clk    (clk),
      .rst    (rst),
      .restart(restart_s),
      .tick   (os_tick_s)
   );

   // RX next-state: start bit checked at tick 8, then one sample every 16 ticks.
   always_comb begin
      rx_state_n = rx_state_r;
      rx_tick_n  = rx_tick_r;
      rx_idx_n   = rx_idx_r;
      rx_shift_n = rx_shift_r;
      rx_perr_n  = rx_perr_r;
      restart_s  = 1'b0;
      deliver_s  = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (fall_s) begin
               rx_state_n = RX_START;
               rx_tick_n  = 4'd0;
               rx_idx_n   = 3'd0;
               rx_perr_n  = 1'b0;
               restart_s  = 1'b1;
            end else begin
               rx_state_n = RX_IDLE;
            end
         end
         RX_START: begin
            if (os_tick_s) begin
               if (rx_tick_r == OS_MID) begin
                  rx_tick_n  = 4'd0;
                  // A high line at mid-start is a glitch, not a frame.
                  rx_state_n = rxd_sync_r ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tick_n = rx_tick_r + 4'd1;
               end
            end else begin
               rx_tick_n = rx_tick_r;
            end
         end
         RX_DATA: begin
            if (os_tick_s) begin
               if (rx_tick_r == OS_LAST) begin
                  rx_tick_n  = 4'd0;
                  rx_shift_n = {rxd_sync_r, rx_shift_r[DATA_BITS-1:1]};
                  if (rx_idx_r == DATA_LAST) begin
                     rx_idx_n   = 3'd0;
                     rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_idx_n = rx_idx_r + 3'd1;
                  end
               end else begin
                  rx_tick_n = rx_tick_r + 4'd1;
               end
            end else begin
               rx_tick_n = rx_tick_r;
            end
         end
         RX_PARITY: begin
            if (os_tick_s) begin
               if (rx_tick_r == OS_LAST) begin
                  rx_tick_n  = 4'd0;
                  rx_perr_n  = rxd_sync_r ^ calc_parity(8'(rx_shift_r), PAR_MODE);
                  rx_state_n = RX_STOP;
               end else begin
                  rx_tick_n = rx_tick_r + 4'd1;
               end
            end else begin
               rx_tick_n = rx_tick_r;
            end
         end
         RX_STOP: begin
            if (os_tick_s) begin
               if (rx_tick_r == OS_LAST) begin
                  rx_tick_n  = 4'd0;
                  deliver_s  = 1'b1;
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_tick_n = rx_tick_r + 4'd1;
               end
            end else begin
               rx_tick_n = rx_tick_r;
            end
         end
         default: begin
            rx_state_n = RX_IDLE;
            rx_tick_n  = 4'd0;
            rx_idx_n   = 3'd0;
         end
      endcase
   end

   // RX state and registered outputs; payload and flags change only on delivery.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_r      <= RX_IDLE;
         rx_tick_r       <= 4'd0;
         rx_idx_r        <= 3'd0;
         rx_shift_r      <= {DATA_BITS{1'b0}};
         rx_perr_r       <= 1'b0;
         rx_data_r       <= {DATA_BITS{1'b0}};
         rx_valid_r      <= 1'b0;
         rx_parity_err_r <= 1'b0;
         rx_frame_err_r  <= 1'b0;
      end else begin
         rx_state_r <= rx_state_n;
         rx_tick_r  <= rx_tick_n;
         rx_idx_r   <= rx_idx_n;
         rx_shift_r <= rx_shift_n;
         rx_perr_r  <= rx_perr_n;
         rx_valid_r <= deliver_s;
         if (deliver_s) begin
            rx_data_r       <= rx_shift_r;
            rx_parity_err_r <= rx_perr_r;
            rx_frame_err_r  <= ~rxd_sync_r;
         end
      end
   end

   assign rx_data       = rx_data_r;
   assign rx_valid      = rx_valid_r;
   assign rx_parity_err = rx_parity_err_r;
   assign rx_frame_err  = rx_frame_err_r;

endmodule

// File: tb/tb_uart_param.sv
// -----------------------------------------------------------------------------
// tb_uart_param
// Two instances at 1 MHz / 62.5 kbaud (16 clocks per bit): an 8E1 instance
// with switchable loopback and a 7O2 instance in permanent loopback. Expected
// frames are built from the frame-format rules; received frames are collected
// by negedge monitors and compared against the payload and injected errors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ns
module tb_uart_param;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         cyc;
   } rx_rec_t;

   logic       clk;
   logic       rst;
   logic       tb_start;
   logic [7:0] tb_data;
   logic       tx_sel;
   logic       loop_a;
   logic       rxd_tb;
   int         cyc;

   logic       tx_busy_a, tx_done_a, txd_a, rxd_a, rx_valid_a, rx_perr_a, rx_ferr_a;
   logic [7:0] rx_data_a;
   logic       tx_busy_b, tx_done_b, txd_b, rxd_b, rx_valid_b, rx_perr_b, rx_ferr_b;
   logic [6:0] rx_data_b;

   logic       txd_m, busy_m, done_m;

   rx_rec_t    rxq_a[$];
   rx_rec_t    rxq_b[$];

   int         n_checks;
   int         n_fail;

   assign rxd_a  = loop_a ? txd_a : rxd_tb;
   assign rxd_b  = txd_b;
   assign txd_m  = tx_sel ? txd_b     : txd_a;
   assign busy_m = tx_sel ? tx_busy_b : tx_busy_a;
   assign done_m = tx_sel ? tx_done_b : tx_done_a;

   uart_param #(
      .CLK_HZ(1_000_000), .BAUD(62_500), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
   ) u_dut_8e1 (
      .clk(clk), .rst(rst),
      .tx_start(tb_start && !tx_sel), .tx_data(tb_data),
      .tx_busy(tx_busy_a), .tx_done(tx_done_a), .txd(txd_a),
      .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a)
   );

   uart_param #(
      .CLK_HZ(1_000_000), .BAUD(62_500), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
   ) u_dut_7o2 (
      .clk(clk), .rst(rst),
      .tx_start(tb_start && tx_sel), .tx_data(tb_data[6:0]),
      .tx_busy(tx_busy_b), .tx_done(tx_done_b), .txd(txd_b),
      .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Receive monitors
   always @(negedge clk) begin
      if (rx_valid_a) rxq_a.push_back('{rx_data_a, rx_perr_a, rx_ferr_a, cyc});
      if (rx_valid_b) rxq_b.push_back('{{1'b0, rx_data_b}, rx_perr_b, rx_ferr_b, cyc});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame as a bit vector (bit i = i-th bit on the line), idle-high beyond the frame.
   function automatic logic [15:0] build_frame(input int data, input int nb, input int pm,
                                               input bit bad_par, input bit bad_stop);
      logic [15:0] f;
      int ones;
      int pos;
      logic p;
      f = 16'hFFFF;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < nb; i++) begin
         f[1 + i] = ((data >> i) & 1) != 0;
         ones += (data >> i) & 1;
      end
      pos = 1 + nb;
      if (pm != 0) begin
         p = (pm == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
         f[pos] = bad_par ? ~p : p;
         pos++;
      end
      if (bad_stop) f[pos] = 1'b0;
      return f;
   endfunction

   task automatic wait_rx(input bit sel, output rx_rec_t rec, output bit ok);
      ok = 1'b0;
      rec = '{8'd0, 1'b0, 1'b0, 0};
      for (int i = 0; i < 400 && !ok; i++) begin
         if (!sel && rxq_a.size() > 0) begin
            rec = rxq_a.pop_front();
            ok = 1'b1;
         end else if (sel && rxq_b.size() > 0) begin
            rec = rxq_b.pop_front();
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   // Send one frame on the selected instance (called at a negedge) and check
   // waveform, busy length, done position and the looped-back reception.
   task automatic send_tx(input bit sel, input logic [7:0] d, output logic [15:0] seen);
      logic [15:0] exp;
      logic [7:0]  dm;
      int nb, len, k, done_at, mism;
      rx_rec_t rec;
      bit ok;
      tx_sel = sel;
      nb  = sel ? 7 : 8;
      dm  = sel ? (d & 8'h7F) : d;
      exp = build_frame(dm, nb, sel ? 1 : 2, 1'b0, 1'b0);
      len = sel ? 11 : 11;
      seen = 16'h0000;
      tb_start = 1'b1;
      tb_data  = d;
      @(negedge clk);
      tb_start = 1'b0;
      tb_data  = 8'($urandom);
      check("tx_start_low", 32'(txd_m), 32'd0);
      check("tx_busy_rise", 32'(busy_m), 32'd1);
      k = 0;
      done_at = -1;
      mism = 0;
      while (busy_m && k < 1000) begin
         if (k / 16 < len) begin
            if (txd_m !== exp[k / 16]) mism++;
            if (k % 16 == 8) seen[k / 16] = txd_m;
         end else begin
            mism++;
         end
         if (done_m) done_at = (done_at == -1) ? k : -2;
         k++;
         @(negedge clk);
      end
      check("tx_busy_len", 32'(k), 32'(len * 16));
      check("tx_done_pos", 32'(done_at), 32'(len * 16 - 1));
      check("tx_wave", 32'(mism), 32'd0);
      check("tx_idle_after", 32'(txd_m), 32'd1);
      wait_rx(sel, rec, ok);
      check("loop_rx_seen", 32'(ok), 32'd1);
      if (ok) begin
         check("loop_rx_data", 32'(rec.data), 32'(dm));
         check("loop_rx_perr", 32'(rec.perr), 32'd0);
         check("loop_rx_ferr", 32'(rec.ferr), 32'd0);
      end
   endtask

   // Drive an 8E1 frame into the 8E1 receiver and check delivery and flags.
   task automatic drive_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [15:0] f;
      int r, lat, mid;
      rx_rec_t rec;
      bit ok;
      f   = build_frame(d, 8, 2, bad_par, bad_stop);
      mid = 16 * (1 + 8 + 1) + 8;
      r   = cyc;
      for (int i = 0; i < 11; i++) begin
         rxd_tb = f[i];
         repeat (16) @(negedge clk);
      end
      rxd_tb = 1'b1;
      repeat (4) @(negedge clk);
      wait_rx(1'b0, rec, ok);
      check("rx_seen", 32'(ok), 32'd1);
      if (ok) begin
         lat = rec.cyc - r;
         check("rx_data", 32'(rec.data), 32'(d));
         check("rx_parity_err", 32'(rec.perr), 32'(bad_par));
         check("rx_frame_err", 32'(rec.ferr), 32'(bad_stop));
         check("rx_latency", 32'(lat >= mid - 2 && lat <= mid + 3), 32'd1);
      end
      check("rx_single_pulse", 32'(rxq_a.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] seen;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      tb_start = 1'b0;
      tb_data  = 8'h00;
      tx_sel   = 1'b0;
      loop_a   = 1'b1;
      rxd_tb   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd_a), 32'd1);
      check("rst_busy", 32'(tx_busy_a), 32'd0);
      check("rst_done", 32'(tx_done_a), 32'd0);
      check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
      check("rst_rx_data", 32'(rx_data_a), 32'd0);
      check("rst_rx_perr", 32'(rx_perr_a), 32'd0);
      check("rst_rx_ferr", 32'(rx_ferr_a), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 8E1 loopback 0xA5 and 7O2 loopback 0x00
      send_tx(1'b0, 8'hA5, seen);
      check("a5_bits", 32'(seen), 32'h054A);
      repeat (5) @(negedge clk);
      send_tx(1'b1, 8'h00, seen);
      check("7o2_zero_bits", 32'(seen), 32'h0700);
      repeat (5) @(negedge clk);

      // Random back-to-back frames on each instance
      for (int i = 0; i < 6; i++) send_tx(1'b0, 8'($urandom), seen);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) send_tx(1'b1, 8'($urandom), seen);
      repeat (5) @(negedge clk);

      // Bench-driven frames into the 8E1 receiver
      loop_a = 1'b0;
      tx_sel = 1'b0;
      repeat (5) @(negedge clk);
      drive_rx(8'h01, 1'b1, 1'b0);
      drive_rx(8'($urandom), 1'b0, 1'b1);
      drive_rx(8'h3C, 1'b0, 1'b0);

      // Short glitch must not start a frame
      rxd_tb = 1'b0;
      repeat (4) @(negedge clk);
      rxd_tb = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_no_rx", 32'(rxq_a.size()), 32'd0);
      drive_rx(8'h5A, 1'b0, 1'b0);

      // Random payloads with random error injection
      for (int i = 0; i < 8; i++) begin
         drive_rx(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      // Reset 40 cycles into a TX frame
      loop_a = 1'b1;
      repeat (5) @(negedge clk);
      tb_start = 1'b1;
      tb_data  = 8'h00;
      @(negedge clk);
      tb_start = 1'b0;
      repeat (39) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_txd", 32'(txd_a), 32'd1);
      check("midrst_busy", 32'(tx_busy_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("midrst_busy_after", 32'(tx_busy_a), 32'd0);
      check("midrst_no_rx", 32'(rxq_a.size() + rxq_b.size()), 32'd0);
      send_tx(1'b0, 8'($urandom), seen);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
